// File: rtl/tnnpar_infer_sched_pkg.sv
// tnnpar_infer_sched_pkg: shared state enum and width helpers for the tnnpar scheduler
package tnnpar_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  function automatic int bits_for(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int pred_bits(input int class_cnt);
    return bits_for(class_cnt);
  endfunction
  function automatic int id_bits(input int req_cnt);
    return bits_for(req_cnt);
  endfunction
  function automatic int settle_bits(input int settle_cycles);
    return bits_for(settle_cycles);
  endfunction
endpackage

// File: rtl/tnnpar_infer_sched_if.sv
// tnnpar_infer_sched_if: request and result handshake bundle of the tnnpar scheduler
interface tnnpar_infer_sched_if
  import tnnpar_sched_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int FEAT_CNT = 11,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6
);
  localparam int PRED_BITS = pred_bits(CLASS_CNT);
  localparam int ID_BITS = id_bits(REQ_CNT);
  logic [REQ_CNT-1:0] req_valid;
  logic [REQ_CNT-1:0] req_ready;
  logic [REQ_CNT*FEAT_CNT*FEAT_BITS-1:0] req_features;
  logic res_valid;
  logic res_ready;
  logic [PRED_BITS-1:0] res_class;
  logic [ID_BITS-1:0] res_id;
  modport master(output req_valid, req_features, res_ready,
                 input req_ready, res_valid, res_class, res_id);
  modport slave(input req_valid, req_features, res_ready,
                output req_ready, res_valid, res_class, res_id);
endinterface

// File: rtl/tnnpar_rr_arbiter.sv
// tnnpar_rr_arbiter: round-robin pick of the first request after ptr, with wrap
module tnnpar_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Walk from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/tnnpar_infer_sched.sv
// tnnpar_infer_sched: round-robin sharing of one tnnpar classifier core among requesters.
// Optional TNN_SCHED_STATS_EN adds saturating inference / per-class result counters.
module tnnpar_infer_sched
  import tnnpar_sched_pkg::*;
#(
  parameter int FEAT_CNT = 11,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6,
  parameter int REQ_CNT = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STAT_BITS = 16,
  localparam int PRED_BITS = pred_bits(CLASS_CNT),
  localparam int ID_BITS = id_bits(REQ_CNT),
  localparam int SW = settle_bits(SETTLE_CYCLES),
  localparam int VW = FEAT_CNT * FEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  tnnpar_infer_sched_if.slave  bus,
  output logic [VW-1:0]        core_features,
  input  logic [PRED_BITS-1:0] core_prediction,
  output logic                 busy
`ifdef TNN_SCHED_STATS_EN
  ,
  output logic [STAT_BITS-1:0]           stat_infer_cnt,
  output logic [CLASS_CNT*STAT_BITS-1:0] stat_class_cnt
`endif
);
  state_t state, state_n;
  logic [ID_BITS-1:0] rr_ptr, idx;
  logic [SW-1:0] settle_cnt;
  logic [REQ_CNT-1:0] gnt;
  logic any, take;
  tnnpar_rr_arbiter #(.N(REQ_CNT), .IW(ID_BITS)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(idx), .any(any)
  );
  assign take = state == IDLE && any;
  assign bus.req_ready = state == IDLE ? gnt : '0;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (take) state_n = SETTLE;
    else if (state == SETTLE && settle_cnt == '0) state_n = HOLD;
    else if (state == HOLD && bus.res_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_features <= '0;
      bus.res_id <= '0;
      bus.res_class <= '0;
      bus.res_valid <= 1'b0;
      rr_ptr <= ID_BITS'(REQ_CNT - 1);
      settle_cnt <= '0;
    end else begin
      if (take) begin
        core_features <= bus.req_features[int'(idx)*VW +: VW];
        bus.res_id <= idx;
        rr_ptr <= idx;
        settle_cnt <= SW'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt == '0 ? '0 : settle_cnt - 1'b1;
        if (settle_cnt == '0) begin
          bus.res_class <= core_prediction;
          bus.res_valid <= 1'b1;
        end
      end
      if (state == HOLD && bus.res_ready) bus.res_valid <= 1'b0;
    end
  end
`ifdef TNN_SCHED_STATS_EN
  logic res_hs;
  assign res_hs = bus.res_valid && bus.res_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_infer_cnt <= '0;
      stat_class_cnt <= '0;
    end else if (res_hs) begin
      if (~&stat_infer_cnt) stat_infer_cnt <= stat_infer_cnt + 1'b1;
      for (int c = 0; c < CLASS_CNT; c++)
        if (bus.res_class == PRED_BITS'(c) && ~&stat_class_cnt[c*STAT_BITS +: STAT_BITS])
          stat_class_cnt[c*STAT_BITS +: STAT_BITS] <= stat_class_cnt[c*STAT_BITS +: STAT_BITS] + 1'b1;
    end
  end
`endif
endmodule
